demux16_buf: RTL and testbench
==============================

DEMUX16_BUF -- requirements
Module: demux16_buf

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 2, entries per output channel buffer (power of two, 2..16).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_data  input  WIDTH  incoming word.
REQ-006 SHALL have port in_sel  input  1  destination: 0 = channel a, 1 = channel b.
REQ-007 SHALL have port in_valid  input  1  in_data/in_sel valid.
REQ-008 SHALL have port in_ready  output  1  word accepted this cycle if in_valid high.
REQ-009 SHALL have ports a_data  output  WIDTH, a_valid  output  1, a_ready  input  1  channel a stream.
REQ-010 SHALL have ports b_data  output  WIDTH, b_valid  output  1, b_ready  input  1  channel b stream.

Function
REQ-011 SHALL accept a word when in_valid && in_ready, writing it into the buffer of the channel named by in_sel.
REQ-012 SHALL drive in_ready combinationally = (selected channel occupancy < DEPTH); it SHALL NOT depend on a_ready/b_ready.
REQ-013 SHALL transfer an output word when x_valid && x_ready; x_valid = occupancy of channel x != 0; x_data = oldest entry, stable while x_valid && !x_ready.
REQ-014 SHALL give latency of exactly one cycle: word accepted at edge N is visible on x_data/x_valid after edge N; no combinational input-to-output bypass.
REQ-015 SHALL preserve order per channel; no ordering relation between a and b.
REQ-016 SHALL allow push and pop on the same channel in one cycle when not full; occupancy unchanged.
REQ-017 SHALL refuse a push to a full channel even if the same channel pops that cycle.
REQ-018 SHALL let a full or stalled channel never block the other channel: in_sel to the non-full channel is accepted.
REQ-019 SHALL wrap read/write pointers modulo DEPTH; occupancy 0..DEPTH held in a counter of clog2(DEPTH)+1 bits.
REQ-020 SHALL leave state unchanged when in_valid is low, regardless of in_sel/in_data.

Reset
REQ-021 SHALL, on rst_n low, immediately clear pointers and occupancies; a_valid = b_valid = 0, in_ready = 1, a_data = b_data = 0.
REQ-022 SHALL discard buffered words when reset asserts mid-operation; no word is emitted after deassertion until a new push.
REQ-023 SHALL accept a push on the first rising edge after rst_n deasserts.

Configuration
REQ-024 SHALL, with macro DEMUX16_BUF_STATS_EN defined, add outputs cnt_a and cnt_b (16 bits each) counting accepted pushes per channel, saturating at 16'hFFFF, reset to 0.
REQ-025 SHALL, without DEMUX16_BUF_STATS_EN, omit cnt_a/cnt_b ports and counter logic entirely; all other behaviour identical.

Structure
REQ-026 SHALL take WIDTH default, DEPTH default and sel encodings (SEL_A = 0, SEL_B = 1) from shared package demux16_pkg.
REQ-027 SHALL implement each channel as sub-module demux16_chan (DEPTH-entry FIFO: push, pop, full, empty, data), instantiated twice.

Verification
REQ-028 Reset release, push 16'h1234 sel=0, a_ready=1 -> a_valid high one cycle later with a_data=16'h1234; b_valid stays 0.
REQ-029 b_ready=0, push 16'h0001,16'h0002 sel=1 -> after 2nd push in_ready=0 for sel=1, in_ready=1 for sel=0; push 16'hAAAA sel=0 accepted.
REQ-030 Channel a full, a_ready=1 and push sel=0 same cycle -> push refused, occupancy drops to 1, push accepted next cycle.
REQ-031 Occupancy 1, push 16'h00FF and pop same cycle on channel b -> occupancy stays 1, outputs emerge in order.
REQ-032 Both channels holding data, rst_n pulsed low mid-cycle -> a_valid=b_valid=0 immediately; no stale word after release.
REQ-033 STATS_EN build: 3 pushes to a, 1 to b -> cnt_a=3, cnt_b=1; cnt_a preloaded near 16'hFFFF saturates at 16'hFFFF.

Source files
------------

// File: rtl/demux16_pkg.sv
// Shared defaults and select encodings for the two-channel buffered demux.
package demux16_pkg;

    localparam int unsigned WIDTH_DEF = 16;
    localparam int unsigned DEPTH_DEF = 2;

    typedef enum logic {
        SEL_A = 1'b0,
        SEL_B = 1'b1
    } sel_e;

    // Occupancy must represent 0..depth inclusive.
    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/demux16_chan.sv
// One output channel: DEPTH-entry FIFO, push refused when full regardless of pop.
module demux16_chan
    import demux16_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] data
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = occ_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    occ_q, occ_d;
    logic             push_ok, pop_ok;

    assign full    = (occ_q == CW'(DEPTH));
    assign empty   = (occ_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Masking with empty keeps data at zero after reset without clearing storage.
    assign data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        occ_d = occ_q;
        unique case ({push_ok, pop_ok})
            2'b10:   occ_d = occ_q + CW'(1);
            2'b01:   occ_d = occ_q - CW'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
            occ_q <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/demux16_buf.sv
// Buffered 1-to-2 demux; each channel has its own FIFO so one stalled channel never blocks the other.
// Optional push counters cnt_a/cnt_b when DEMUX16_BUF_STATS_EN is defined.
module demux16_buf
    import demux16_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready
`ifdef DEMUX16_BUF_STATS_EN
    ,
    output logic [15:0]      cnt_a,
    output logic [15:0]      cnt_b
`endif
);

    logic a_full, a_empty, b_full, b_empty;
    logic push_a, push_b;

    assign in_ready = (in_sel == SEL_B) ? !b_full : !a_full;
    assign push_a   = in_valid && in_ready && (in_sel == SEL_A);
    assign push_b   = in_valid && in_ready && (in_sel == SEL_B);
    assign a_valid  = !a_empty;
    assign b_valid  = !b_empty;

    demux16_chan #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_chan_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_a),
        .push_data (in_data),
        .pop       (a_ready),
        .full      (a_full),
        .empty     (a_empty),
        .data      (a_data)
    );

    demux16_chan #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_chan_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_b),
        .push_data (in_data),
        .pop       (b_ready),
        .full      (b_full),
        .empty     (b_empty),
        .data      (b_data)
    );

`ifdef DEMUX16_BUF_STATS_EN
    logic [15:0] cnt_a_q, cnt_b_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            if (push_a && (cnt_a_q != 16'hFFFF)) cnt_a_q <= cnt_a_q + 16'd1;
            if (push_b && (cnt_b_q != 16'hFFFF)) cnt_b_q <= cnt_b_q + 16'd1;
        end
    end

    assign cnt_a = cnt_a_q;
    assign cnt_b = cnt_b_q;
`endif

endmodule

// File: tb/tb_demux16_buf.sv
// Scoreboard bench for demux16_buf: queues model each channel's FIFO, a negedge monitor checks handshakes.
module tb_demux16_buf;

    localparam int W = 16;
    localparam int D = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_sel = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a_data, b_data;
    logic         a_valid, b_valid;
    logic         a_ready = 1'b0;
    logic         b_ready = 1'b0;
`ifdef DEMUX16_BUF_STATS_EN
    logic [15:0]  cnt_a, cnt_b;
`endif

    int tests = 0;
    int fails = 0;

    logic [W-1:0] exp_a[$];
    logic [W-1:0] exp_b[$];
    logic [W-1:0] mon_word;
    bit           mon_rdy;

    always #5 clk = ~clk;

    demux16_buf #(
        .WIDTH (W),
        .DEPTH (D)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready)
`ifdef DEMUX16_BUF_STATS_EN
        ,
        .cnt_a    (cnt_a),
        .cnt_b    (cnt_b)
`endif
    );

    // Model occupancy is the queue size; compare before applying this edge's pushes and pops.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            mon_rdy = in_sel ? (exp_b.size() < D) : (exp_a.size() < D);
            tests++;
            if (in_ready !== mon_rdy) begin
                fails++;
                $display("FAIL mon_in_ready: got %b want %b t=%0t", in_ready, mon_rdy, $time);
            end
            tests++;
            if (a_valid !== (exp_a.size() != 0)) begin
                fails++;
                $display("FAIL mon_a_valid: got %b want %b t=%0t", a_valid, exp_a.size() != 0, $time);
            end
            tests++;
            if (b_valid !== (exp_b.size() != 0)) begin
                fails++;
                $display("FAIL mon_b_valid: got %b want %b t=%0t", b_valid, exp_b.size() != 0, $time);
            end
            if (a_ready && exp_a.size() != 0) begin
                mon_word = exp_a.pop_front();
                tests++;
                if (a_data !== mon_word) begin
                    fails++;
                    $display("FAIL mon_a_data: got %h want %h t=%0t", a_data, mon_word, $time);
                end
            end
            if (b_ready && exp_b.size() != 0) begin
                mon_word = exp_b.pop_front();
                tests++;
                if (b_data !== mon_word) begin
                    fails++;
                    $display("FAIL mon_b_data: got %h want %h t=%0t", b_data, mon_word, $time);
                end
            end
            if (in_valid && mon_rdy) begin
                if (in_sel) exp_b.push_back(in_data);
                else        exp_a.push_back(in_data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [W-1:0] d);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
    endtask

    task automatic drain();
        int n;
        drive(1'b0, 1'b0, '0);
        a_ready = 1'b1;
        b_ready = 1'b1;
        n = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 20) begin
            tick();
            n++;
        end
        tests++;
        if (exp_a.size() != 0 || exp_b.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: left a=%0d b=%0d want 0", exp_a.size(), exp_b.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, '0);
        a_ready = 1'b0;
        b_ready = 1'b0;
        exp_a.delete();
        exp_b.delete();
        tick();
        tick();
        tests++;
        if ({a_valid, b_valid} !== 2'b00) begin
            fails++;
            $display("FAIL reset_valid: got %b%b want 00", a_valid, b_valid);
        end
        tests++;
        if (a_data !== '0 || b_data !== '0) begin
            fails++;
            $display("FAIL reset_data: got %h/%h want 0000/0000", a_data, b_data);
        end
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready_a: got %b want 1", in_ready);
        end
        in_sel = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready_b: got %b want 1", in_ready);
        end
        in_sel = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Push on the first edge after reset release, visible one cycle later.
    task automatic test_basic();
        a_ready = 1'b1;
        drive(1'b1, 1'b0, 16'h1234);
        tick();
        drive(1'b0, 1'b0, '0);
        tests++;
        if (a_valid !== 1'b1 || a_data !== 16'h1234) begin
            fails++;
            $display("FAIL basic_a: got v=%b d=%h want v=1 d=1234", a_valid, a_data);
        end
        tests++;
        if (b_valid !== 1'b0) begin
            fails++;
            $display("FAIL basic_b_valid: got %b want 0", b_valid);
        end
        tick();
        drain();
    endtask

    task automatic test_backpressure();
        a_ready = 1'b1;
        b_ready = 1'b0;
        drive(1'b1, 1'b1, 16'h0001);
        tick();
        drive(1'b1, 1'b1, 16'h0002);
        tick();
        drive(1'b0, 1'b1, 16'h0000);
        #1;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL bp_ready_b_full: got %b want 0", in_ready);
        end
        in_sel = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_ready_a_free: got %b want 1", in_ready);
        end
        drive(1'b1, 1'b0, 16'hAAAA);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, '0);
        tests++;
        if (a_valid !== 1'b1 || a_data !== 16'hAAAA) begin
            fails++;
            $display("FAIL bp_a_accept: got v=%b d=%h want v=1 d=aaaa", a_valid, a_data);
        end
        drain();
    endtask

    task automatic test_full_pop();
        a_ready = 1'b0;
        b_ready = 1'b0;
        drive(1'b1, 1'b0, 16'h0A01);
        tick();
        drive(1'b1, 1'b0, 16'h0A02);
        tick();
        a_ready = 1'b1;
        drive(1'b1, 1'b0, 16'h0A03);
        #1;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL fullpop_refuse: got %b want 0", in_ready);
        end
        tick();
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL fullpop_retry_ready: got %b want 1", in_ready);
        end
        tick();
        drive(1'b0, 1'b0, '0);
        drain();
    endtask

    task automatic test_same_cycle();
        a_ready = 1'b0;
        b_ready = 1'b0;
        drive(1'b1, 1'b1, 16'h0B01);
        tick();
        b_ready = 1'b1;
        drive(1'b1, 1'b1, 16'h00FF);
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL same_ready: got %b want 1", in_ready);
        end
        tick();
        drive(1'b0, 1'b0, '0);
        b_ready = 1'b0;
        tests++;
        if (b_valid !== 1'b1 || b_data !== 16'h00FF) begin
            fails++;
            $display("FAIL same_b: got v=%b d=%h want v=1 d=00ff", b_valid, b_data);
        end
        drain();
    endtask

    task automatic test_mid_reset();
        a_ready = 1'b0;
        b_ready = 1'b0;
        drive(1'b1, 1'b0, 16'hC0DE);
        tick();
        drive(1'b1, 1'b1, 16'hBEEF);
        tick();
        drive(1'b0, 1'b0, '0);
        #2;
        rst_n = 1'b0;
        exp_a.delete();
        exp_b.delete();
        #1;
        tests++;
        if ({a_valid, b_valid} !== 2'b00 || a_data !== '0 || b_data !== '0) begin
            fails++;
            $display("FAIL midrst_clear: got v=%b%b d=%h/%h want v=00 d=0", a_valid, b_valid,
                     a_data, b_data);
        end
        tick();
        rst_n = 1'b1;
        a_ready = 1'b1;
        b_ready = 1'b1;
        tick();
        tick();
        tests++;
        if ({a_valid, b_valid} !== 2'b00) begin
            fails++;
            $display("FAIL midrst_stale: got %b%b want 00", a_valid, b_valid);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), W'($urandom));
            a_ready = ($urandom_range(0, 3) != 0);
            b_ready = ($urandom_range(0, 2) == 0);
            tick();
        end
        drain();
    endtask

`ifdef DEMUX16_BUF_STATS_EN
    task automatic test_stats();
        test_reset();
        a_ready = 1'b1;
        b_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, (i == 3), W'(16'h5100 + i));
            tick();
        end
        drive(1'b0, 1'b0, '0);
        tests++;
        if (cnt_a !== 16'd3 || cnt_b !== 16'd1) begin
            fails++;
            $display("FAIL stats_count: got a=%0d b=%0d want a=3 b=1", cnt_a, cnt_b);
        end
        drive(1'b1, 1'b0, 16'h7777);
        for (int i = 0; i < 65535; i++) tick();
        tests++;
        if (cnt_a !== 16'hFFFF) begin
            fails++;
            $display("FAIL stats_saturate: got %h want ffff", cnt_a);
        end
        tick();
        tests++;
        if (cnt_a !== 16'hFFFF || cnt_b !== 16'd1) begin
            fails++;
            $display("FAIL stats_hold: got a=%h b=%0d want a=ffff b=1", cnt_a, cnt_b);
        end
        drain();
    endtask
`endif

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_full_pop();
        test_same_cycle();
        test_mid_reset();
        test_random();
`ifdef DEMUX16_BUF_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
